// File: rtl/stream_upsizer_if.sv
// Narrow-in / wide-out stream bundle for the width up-converter.
// slave is the converter's view; master is the driving/consuming environment.
interface stream_upsizer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 2
);
  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_WIDTH-1:0]         in_data;
  logic                          in_last;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH*RATIO-1:0]   out_data;
  logic [RATIO-1:0]              out_keep;
  logic                          out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow beats into one wide word, little-endian lanes; in_last
// closes a word early and the keep mask marks which lanes carry data.
module stream_upsizer #(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_upsizer_if.slave  bus
);
  localparam int IDX_W = $clog2(RATIO);
  localparam int OUT_W = DATA_WIDTH * RATIO;

  logic [IDX_W-1:0] idx_reg;
  logic [OUT_W-1:0] acc_data_reg;
  logic [RATIO-1:0] acc_keep_reg;

  logic             out_valid_reg;
  logic [OUT_W-1:0] out_data_reg;
  logic [RATIO-1:0] out_keep_reg;
  logic             out_last_reg;

  logic [OUT_W-1:0] out_data_next;
  logic [RATIO-1:0] out_keep_next;
  logic             in_ready_int;
  logic             beat_fire;
  logic             word_done;

  // A held word may be replaced on the same edge it drains, so only
  // a stalled output blocks the input side.
  assign in_ready_int = !out_valid_reg || bus.out_ready;
  assign beat_fire    = bus.in_valid && in_ready_int;
  assign word_done    = beat_fire && ((idx_reg == IDX_W'(RATIO - 1)) || bus.in_last);

  // Accumulator contents with the incoming beat merged into lane idx.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    logic lane_hit;
    assign lane_hit = (idx_reg == IDX_W'(gi));
    assign out_data_next[gi*DATA_WIDTH +: DATA_WIDTH] =
      lane_hit ? bus.in_data : acc_data_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    assign out_keep_next[gi] = lane_hit | acc_keep_reg[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg      <= '0;
      acc_data_reg <= '0;
      acc_keep_reg <= '0;
    end else if (beat_fire) begin
      if (word_done) begin
        idx_reg      <= '0;
        acc_data_reg <= '0;
        acc_keep_reg <= '0;
      end else begin
        idx_reg      <= idx_reg + IDX_W'(1);
        acc_data_reg <= out_data_next;
        acc_keep_reg <= out_keep_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_keep_reg  <= '0;
      out_last_reg  <= 1'b0;
    end else if (word_done) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= out_data_next;
      out_keep_reg  <= out_keep_next;
      out_last_reg  <= bus.in_last;
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_keep  = out_keep_reg;
  assign bus.out_last  = out_last_reg;
endmodule

// File: tb/tb_stream_upsizer.sv
// Scoreboarded bench for stream_upsizer at RATIO=2 and RATIO=4; a lane-list
// model predicts words, a negedge monitor pops and compares.
module tb_stream_upsizer;
  logic clk = 1'b0;
  logic rst2_n, rst4_n;
  always #5 clk = ~clk;

  stream_upsizer_if #(.DATA_WIDTH(32), .RATIO(2)) u2 ();
  stream_upsizer_if #(.DATA_WIDTH(32), .RATIO(4)) u4 ();

  stream_upsizer #(.DATA_WIDTH(32), .RATIO(2)) dut2 (.clk(clk), .rst_n(rst2_n), .bus(u2));
  stream_upsizer #(.DATA_WIDTH(32), .RATIO(4)) dut4 (.clk(clk), .rst_n(rst4_n), .bus(u4));

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   keep;
    logic         last;
  } word_t;

  word_t       exp_q  [2][$];
  logic [31:0] pend_q [2][$];
  int checks   = 0;
  int failures = 0;
  int pops [2] = '{0, 0};
  int cyc      = 0;
  bit done;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic in_rdy(input int s);
    return (s == 0) ? u2.in_ready : u4.in_ready;
  endfunction
  function automatic logic out_vld(input int s);
    return (s == 0) ? u2.out_valid : u4.out_valid;
  endfunction
  function automatic logic out_rdy(input int s);
    return (s == 0) ? u2.out_ready : u4.out_ready;
  endfunction
  function automatic word_t out_word(input int s);
    word_t w;
    if (s == 0) begin
      w.data = {64'b0, u2.out_data}; w.keep = {2'b0, u2.out_keep}; w.last = u2.out_last;
    end else begin
      w.data = u4.out_data; w.keep = u4.out_keep; w.last = u4.out_last;
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive_in(input int s, input logic v, input logic [31:0] d, input logic l);
    if (s == 0) begin u2.in_valid = v; u2.in_data = d; u2.in_last = l; end
    else        begin u4.in_valid = v; u4.in_data = d; u4.in_last = l; end
  endtask

  task automatic set_ordy(input int s, input logic r);
    if (s == 0) u2.out_ready = r; else u4.out_ready = r;
  endtask

  // Reference: collect beats; a word is every RATIO beats or up to a last beat.
  task automatic model_beat(input int s, input logic [31:0] d, input logic l);
    word_t w;
    int n;
    n = (s == 0) ? 2 : 4;
    pend_q[s].push_back(d);
    if (pend_q[s].size() == n || l) begin
      w = '0;
      for (int i = 0; i < pend_q[s].size(); i++) begin
        w.data[32*i +: 32] = pend_q[s][i];
        w.keep[i] = 1'b1;
      end
      w.last = l;
      exp_q[s].push_back(w);
      pend_q[s].delete();
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_beat(input int s, input logic [31:0] d, input logic l);
    int waited;
    waited = 0;
    drive_in(s, 1'b1, d, l);
    forever begin
      @(negedge clk);
      if (in_rdy(s)) begin
        model_beat(s, d, l);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      waited++;
      if (waited > 200) begin
        checks++; failures++;
        $display("FAIL beat_accept_timeout r%0d actual=stalled required=accepted", (s == 0) ? 2 : 4);
        break;
      end
    end
  endtask

  initial begin
    logic  hold [2];
    word_t held [2];
    word_t w, e;
    hold = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        if (((s == 0) ? rst2_n : rst4_n) !== 1'b1) begin
          hold[s] = 1'b0;
          continue;
        end
        w = out_word(s);
        check($sformatf("in_ready_rule_r%0d", (s == 0) ? 2 : 4), in_rdy(s), !out_vld(s) || out_rdy(s));
        if (hold[s]) begin
          check("stall_valid", out_vld(s), 1'b1);
          check("stall_data", w.data, held[s].data);
          check("stall_keep_last", {w.keep, w.last}, {held[s].keep, held[s].last});
        end
        if (out_vld(s) && out_rdy(s)) begin
          $display("txn r%0d data=%h keep=%b last=%b", (s == 0) ? 2 : 4, w.data, w.keep, w.last);
          if (exp_q[s].size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_word r%0d actual=%0h required=none", (s == 0) ? 2 : 4, w.data);
          end else begin
            e = exp_q[s].pop_front();
            check("word_data", w.data, e.data);
            check("word_keep", w.keep, e.keep);
            check("word_last", w.last, e.last);
          end
          pops[s]++;
        end
        hold[s] = out_vld(s) && !out_rdy(s);
        held[s] = w;
      end
    end
  end

  initial begin
    int p0, c0, c1, wt;
    rst2_n = 1'b0; rst4_n = 1'b0;
    drive_in(0, 1'b0, 32'h0, 1'b0); drive_in(1, 1'b0, 32'h0, 1'b0);
    set_ordy(0, 1'b1); set_ordy(1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", u2.out_valid, 1'b0);
    check("reset_out_keep", u2.out_keep, 2'b00);
    check("reset_in_ready", u2.in_ready, 1'b1);
    check("reset_out_data", u2.out_data, 64'h0);
    check("reset_out_valid_r4", u4.out_valid, 1'b0);
    @(posedge clk); #1;
    rst2_n = 1'b1; rst4_n = 1'b1;
    @(posedge clk); #1;

    // Basic pack
    send_beat(0, 32'hDEADBEEF, 1'b0);
    send_beat(0, 32'h12345678, 1'b0);
    drive_in(0, 1'b0, 32'h0, 1'b0);
    check("pack_latency_valid", u2.out_valid, 1'b1);
    check("pack_data", u2.out_data, 64'h12345678_DEADBEEF);
    check("pack_keep", u2.out_keep, 2'b11);
    check("pack_last", u2.out_last, 1'b0);
    repeat (2) begin @(posedge clk); #1; end

    // Partial word closed by last
    send_beat(0, 32'hAAAABBBB, 1'b1);
    drive_in(0, 1'b0, 32'h0, 1'b0);
    check("partial_data", u2.out_data, 64'h00000000_AAAABBBB);
    check("partial_keep", u2.out_keep, 2'b01);
    check("partial_last", u2.out_last, 1'b1);
    repeat (2) begin @(posedge clk); #1; end

    // Backpressure with in_valid held high
    set_ordy(0, 1'b0);
    fork
      begin
        for (int i = 0; i < 6; i++) send_beat(0, 32'h4000_0000 + i, 1'b0);
        drive_in(0, 1'b0, 32'h0, 1'b0);
      end
      begin
        int w2;
        w2 = 0;
        do begin @(negedge clk); w2++; end while (!u2.out_valid && w2 < 50);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("bp_in_ready_low", u2.in_ready, 1'b0);
        end
        @(posedge clk); #1;
        set_ordy(0, 1'b1);
      end
    join
    repeat (3) begin @(posedge clk); #1; end

    // Back-to-back streaming
    p0 = pops[0];
    c0 = cyc;
    for (int i = 1; i <= 8; i++) send_beat(0, i, 1'b0);
    c1 = cyc;
    drive_in(0, 1'b0, 32'h0, 1'b0);
    check("stream_cycles", c1 - c0, 8);
    repeat (2) begin @(posedge clk); #1; end
    check("stream_words", pops[0] - p0, 4);

    // Reset in the middle of a RATIO=4 word
    send_beat(1, 32'hA1, 1'b0);
    send_beat(1, 32'hA2, 1'b0);
    drive_in(1, 1'b0, 32'h0, 1'b0);
    rst4_n = 1'b0;
    pend_q[1].delete();
    exp_q[1].delete();
    @(negedge clk);
    check("midreset_valid", u4.out_valid, 1'b0);
    @(posedge clk); #1;
    rst4_n = 1'b1;
    repeat (2) begin @(negedge clk); check("post_reset_valid", u4.out_valid, 1'b0); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_beat(1, 32'h10 + i, 1'b0);
    drive_in(1, 1'b0, 32'h0, 1'b0);
    check("r4_data", u4.out_data, 128'h00000013_00000012_00000011_00000010);
    check("r4_keep", u4.out_keep, 4'hF);
    check("r4_last", u4.out_last, 1'b0);
    repeat (2) begin @(posedge clk); #1; end

    // Randomized traffic with random backpressure on both widths
    for (int s = 0; s < 2; s++) begin
      done = 1'b0;
      fork
        begin
          for (int i = 0; i < 150; i++) begin
            send_beat(s, $urandom, (i == 149) || ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) begin
              drive_in(s, 1'b0, 32'h0, 1'b0);
              repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
            end
          end
          drive_in(s, 1'b0, 32'h0, 1'b0);
          done = 1'b1;
        end
        begin
          while (!done) begin
            set_ordy(s, $urandom_range(0, 2) != 0);
            @(posedge clk); #1;
          end
        end
      join
      set_ordy(s, 1'b1);
      wt = 0;
      while (exp_q[s].size() != 0 && wt < 100) begin @(posedge clk); #1; wt++; end
      check($sformatf("drain_empty_r%0d", (s == 0) ? 2 : 4), exp_q[s].size(), 0);
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
